// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU: ISA opcodes, ALU op codes, FSM states.
package cpu_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned OPC_W    = 4;
    localparam int unsigned ALU_OP_W = 3;

    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
    localparam logic [OPC_W-1:0] OP_AND = 4'h4;
    localparam logic [OPC_W-1:0] OP_OR  = 4'h5;
    localparam logic [OPC_W-1:0] OP_XOR = 4'h6;
    localparam logic [OPC_W-1:0] OP_STA = 4'h7;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h8;
    localparam logic [OPC_W-1:0] OP_JZ  = 4'h9;
    localparam logic [OPC_W-1:0] OP_JC  = 4'hA;
    localparam logic [OPC_W-1:0] OP_LDI = 4'hB;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

    localparam logic [ALU_OP_W-1:0] ALU_ADD    = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB    = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_AND    = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OR     = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_XOR    = 3'b100;
    localparam logic [ALU_OP_W-1:0] ALU_PASS_B = 3'b101;
    localparam logic [ALU_OP_W-1:0] ALU_PASS_A = 3'b110;

    typedef enum logic [2:0] {
        ST_START,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_RD,
        ST_EXEC_ALU,
        ST_EXEC_WR,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_CTRL,
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_HALT,
        CLS_ILLEGAL
    } iclass_t;

    // Decoder result for one opcode.
    typedef struct packed {
        iclass_t                 iclass;
        logic [ALU_OP_W-1:0]     alu_op;
        logic                    flag_en;
    } decode_t;

endpackage

// File: rtl/cpu_instr_decode.sv
// Opcode -> instruction class, ALU operation and flag-update enable.
module cpu_instr_decode
    import cpu_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output decode_t          dec
);

    // Pure table lookup; undefined opcodes fall to the illegal class.
    always_comb begin
        dec.iclass  = CLS_ILLEGAL;
        dec.alu_op  = ALU_ADD;
        dec.flag_en = 1'b0;
        case (opcode)
            OP_NOP, OP_JMP, OP_JZ, OP_JC: dec.iclass = CLS_CTRL;
            OP_ADD: begin dec.iclass = CLS_ALU; dec.alu_op = ALU_ADD; dec.flag_en = 1'b1; end
            OP_SUB: begin dec.iclass = CLS_ALU; dec.alu_op = ALU_SUB; dec.flag_en = 1'b1; end
            OP_AND: begin dec.iclass = CLS_ALU; dec.alu_op = ALU_AND; dec.flag_en = 1'b1; end
            OP_OR:  begin dec.iclass = CLS_ALU; dec.alu_op = ALU_OR;  dec.flag_en = 1'b1; end
            OP_XOR: begin dec.iclass = CLS_ALU; dec.alu_op = ALU_XOR; dec.flag_en = 1'b1; end
            OP_LDA, OP_LDI: begin dec.iclass = CLS_LOAD; dec.alu_op = ALU_PASS_B; end
            OP_STA: begin dec.iclass = CLS_STORE; dec.alu_op = ALU_PASS_A; end
            OP_HLT: dec.iclass = CLS_HALT;
            default: dec.iclass = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/cpu_control.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator datapath.
// Owns pc, ir, flags and state; every other output is decoded from state+ir.
module cpu_control
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC        = 4'h0,
    parameter bit                HALT_ON_ILLEGAL = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic [ALU_OP_W-1:0] alu_op,
    input  logic                alu_zero,
    input  logic                alu_carry,
    output logic                b_we,
    output logic                b_sel,
    output logic [ADDR_W-1:0]   imm,
    output logic                acc_we,
    output logic                flag_z,
    output logic                flag_c,
    output logic [ADDR_W-1:0]   pc,
    output logic                halted,
    output logic                illegal
);

    state_t              state, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir, ir_d;
    logic                fz, fz_d, fc, fc_d;
    logic [OPC_W-1:0]    opcode;
    logic [ADDR_W-1:0]   operand;
    decode_t             dec;

    assign opcode  = ir[DATA_W-1:ADDR_W];
    assign operand = ir[ADDR_W-1:0];
    assign imm     = operand;
    assign pc      = pc_q;
    assign flag_z  = fz;
    assign flag_c  = fc;

    cpu_instr_decode u_decode (
        .opcode (opcode),
        .dec    (dec)
    );

    // Architectural state; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_START;
            pc_q  <= RESET_PC;
            ir    <= '0;
            fz    <= 1'b0;
            fc    <= 1'b0;
        end else begin
            state <= state_d;
            pc_q  <= pc_d;
            ir    <= ir_d;
            fz    <= fz_d;
            fc    <= fc_d;
        end
    end

    // Next state and strobes; address/we depend only on state+ir so they hold while unacked.
    always_comb begin
        state_d  = state;
        pc_d     = pc_q;
        ir_d     = ir;
        fz_d     = fz;
        fc_d     = fc;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        alu_op   = ALU_ADD;
        b_we     = 1'b0;
        b_sel    = 1'b0;
        acc_we   = 1'b0;
        halted   = 1'b0;
        illegal  = 1'b0;
        case (state)
            ST_START: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_FETCH;
                case (dec.iclass)
                    CLS_CTRL: begin
                        if ((opcode == OP_JMP) ||
                            (opcode == OP_JZ && fz) ||
                            (opcode == OP_JC && fc)) begin
                            pc_d = operand;
                        end
                    end
                    CLS_ALU:   state_d = ST_EXEC_RD;
                    CLS_LOAD:  state_d = (opcode == OP_LDI) ? ST_EXEC_ALU : ST_EXEC_RD;
                    CLS_STORE: state_d = ST_EXEC_WR;
                    CLS_HALT:  state_d = ST_HALT;
                    default: begin
                        illegal = 1'b1;
                        if (HALT_ON_ILLEGAL) state_d = ST_HALT;
                    end
                endcase
            end
            ST_EXEC_RD: begin
                mem_req  = 1'b1;
                mem_addr = operand;
                if (mem_ack) begin
                    b_we    = 1'b1;
                    state_d = ST_EXEC_ALU;
                end
            end
            ST_EXEC_ALU: begin
                alu_op  = dec.alu_op;
                b_sel   = (opcode == OP_LDI);
                acc_we  = 1'b1;
                if (dec.flag_en) begin
                    fz_d = alu_zero;
                    fc_d = alu_carry;
                end
                state_d = ST_FETCH;
            end
            ST_EXEC_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = operand;
                alu_op   = ALU_PASS_A;
                if (mem_ack) state_d = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_START;
        endcase
    end

endmodule
